core_mem_arb: RTL and testbench



---
 rtl/core_mem_arb_pkg.sv | 41 ++++
 rtl/core_arb_tag_fifo.sv | 56 +++++
 rtl/core_mem_arb.sv | 124 ++++++++++++
 tb/tb_core_mem_arb.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_arb_pkg.sv
// Shared constants, request-register layout and per-requester state for the core memory arbiter.
// Pure definitions; no timing or backpressure behaviour of its own.
package core_mem_arb_pkg;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  localparam int COP_WR = 0;
  localparam int COP_NC = 1;

  localparam logic [2:0] FETCH_COP  = 3'b000;
  localparam logic [2:0] FETCH_SIZE = 3'b100;

  typedef enum logic [1:0] {
    RQ_IDLE     = 2'd0,
    RQ_QUEUED   = 2'd1,
    RQ_WAIT_RSP = 2'd2
  } rq_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  cop;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        src;
  } mreq_t;

  function automatic rq_state_e rq_next(input rq_state_e st, input logic grant,
                                        input logic acc, input logic ack);
    rq_state_e nxt;
    nxt = st;
    case (st)
      RQ_IDLE:     if (grant) nxt = RQ_QUEUED;
      RQ_QUEUED:   if (acc)   nxt = RQ_WAIT_RSP;
      RQ_WAIT_RSP: if (ack)   nxt = RQ_IDLE;
      default:     nxt = RQ_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/core_arb_tag_fifo.sv
// In-order 1-bit source-tag FIFO; pop data is combinational from the head, push/pop take effect at the clock.
// No backpressure: pushes while full are dropped unless a pop frees the slot in the same cycle.
module core_arb_tag_fifo #(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          push_dat,
  input  logic          pop,
  output logic          pop_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/core_mem_arb.sv
// Round-robin/fixed-priority arbiter of core fetch and load/store onto one registered memory port.
// Grant in N -> m_req_val in N+1; output register holds while ~m_req_rdy; responses routed combinationally.
module core_mem_arb
  import core_mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit RR_EN           = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_val,
  input  logic [31:0] i_req_addr,
  output logic        i_req_ack,
  output logic [31:0] i_ack_rdata,
  input  logic        d_req_val,
  input  logic [31:0] d_req_addr,
  input  logic [2:0]  d_req_cop,
  input  logic [31:0] d_req_wdata,
  input  logic [2:0]  d_req_size,
  output logic        d_req_ack,
  output logic [31:0] d_ack_rdata,
  output logic        m_req_val,
  input  logic        m_req_rdy,
  output logic [31:0] m_req_addr,
  output logic [2:0]  m_req_cop,
  output logic [31:0] m_req_wdata,
  output logic [2:0]  m_req_size,
  input  logic        m_rsp_val,
  input  logic [31:0] m_rsp_rdata,
  output logic        arb_err
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int CCW = CW + 1;

  rq_state_e      i_st, i_st_nxt;
  rq_state_e      d_st, d_st_nxt;
  mreq_t          out_q;
  logic           last_d;
  logic           accept, out_free, credit_ok;
  logic           i_elig, d_elig, grant_i, grant_d;
  logic [CW-1:0]  tag_cnt;
  logic [CCW-1:0] credit_cnt;
  logic           tag_full, tag_empty, tag_head, tag_push, tag_pop;

  assign accept   = m_req_val & m_req_rdy;
  assign out_free = ~m_req_val | m_req_rdy;

  // A register being accepted this cycle still holds a credit: it lands in the tag FIFO next cycle.
  assign credit_cnt = {1'b0, tag_cnt} + CCW'(m_req_val);
  assign credit_ok  = credit_cnt < CCW'(MAX_OUTSTANDING);

  assign i_elig  = i_req_val & (i_st == RQ_IDLE) & credit_ok & out_free;
  assign d_elig  = d_req_val & (d_st == RQ_IDLE) & credit_ok & out_free;
  assign grant_d = d_elig & (~i_elig | ~RR_EN | ~last_d);
  assign grant_i = i_elig & ~grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req_val <= 1'b0;
      out_q     <= '0;
      last_d    <= 1'b0;
      arb_err   <= 1'b0;
    end else begin
      if (grant_d) begin
        m_req_val <= 1'b1;
        out_q     <= '{addr: d_req_addr, cop: d_req_cop, wdata: d_req_wdata,
                       size: d_req_size, src: SRC_D};
        last_d    <= 1'b1;
      end else if (grant_i) begin
        m_req_val <= 1'b1;
        out_q     <= '{addr: i_req_addr, cop: FETCH_COP, wdata: 32'h0,
                       size: FETCH_SIZE, src: SRC_I};
        last_d    <= 1'b0;
      end else if (accept) begin
        m_req_val <= 1'b0;
      end
      if (m_rsp_val && tag_empty) arb_err <= 1'b1;
    end
  end

  assign m_req_addr  = out_q.addr;
  assign m_req_cop   = out_q.cop;
  assign m_req_wdata = out_q.wdata;
  assign m_req_size  = out_q.size;

  assign tag_push = accept & ~tag_full;
  assign tag_pop  = m_rsp_val & ~tag_empty;

  core_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tag_push),
    .push_dat (out_q.src),
    .pop      (tag_pop),
    .pop_dat  (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (tag_cnt)
  );

  assign i_req_ack   = tag_pop & (tag_head == SRC_I);
  assign d_req_ack   = tag_pop & (tag_head == SRC_D);
  assign i_ack_rdata = i_req_ack ? m_rsp_rdata : 32'h0;
  assign d_ack_rdata = d_req_ack ? m_rsp_rdata : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_st <= RQ_IDLE;
      d_st <= RQ_IDLE;
    end else begin
      i_st <= i_st_nxt;
      d_st <= d_st_nxt;
    end
  end

  always_comb begin
    i_st_nxt = i_st;
    d_st_nxt = d_st;
    i_st_nxt = rq_next(i_st, grant_i, accept && (out_q.src == SRC_I), i_req_ack);
    d_st_nxt = rq_next(d_st, grant_d, accept && (out_q.src == SRC_D), d_req_ack);
  end

endmodule

// File: tb/tb_core_mem_arb.sv
// Scoreboard bench for core_mem_arb: expected downstream requests and acks are queued by the
// stimulus, a negedge monitor checks them, and a small memory model answers accepted requests.
module tb_core_mem_arb;
  import core_mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_val = 1'b0;
  logic [31:0] i_req_addr = 32'h0;
  logic        i_req_ack;
  logic [31:0] i_ack_rdata;
  logic        d_req_val = 1'b0;
  logic [31:0] d_req_addr = 32'h0;
  logic [2:0]  d_req_cop = 3'b0;
  logic [31:0] d_req_wdata = 32'h0;
  logic [2:0]  d_req_size = 3'b0;
  logic        d_req_ack;
  logic [31:0] d_ack_rdata;
  logic        m_req_val;
  logic        m_req_rdy = 1'b0;
  logic [31:0] m_req_addr;
  logic [2:0]  m_req_cop;
  logic [31:0] m_req_wdata;
  logic [2:0]  m_req_size;
  logic        m_rsp_val = 1'b0;
  logic [31:0] m_rsp_rdata = 32'h0;
  logic        arb_err;

  core_mem_arb #(.MAX_OUTSTANDING(2), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_val(i_req_val), .i_req_addr(i_req_addr), .i_req_ack(i_req_ack), .i_ack_rdata(i_ack_rdata),
    .d_req_val(d_req_val), .d_req_addr(d_req_addr), .d_req_cop(d_req_cop), .d_req_wdata(d_req_wdata),
    .d_req_size(d_req_size), .d_req_ack(d_req_ack), .d_ack_rdata(d_ack_rdata),
    .m_req_val(m_req_val), .m_req_rdy(m_req_rdy), .m_req_addr(m_req_addr), .m_req_cop(m_req_cop),
    .m_req_wdata(m_req_wdata), .m_req_size(m_req_size),
    .m_rsp_val(m_rsp_val), .m_rsp_rdata(m_rsp_rdata), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        src;
    logic [31:0] addr;
    logic [2:0]  cop;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] rdata;
  } exp_req_t;

  typedef struct {
    logic        src;
    logic [31:0] rdata;
    int          t;
  } inflight_t;

  exp_req_t  exp_req_q[$];
  inflight_t mem_q[$];
  inflight_t exp_ack_q[$];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int n_i_ack = 0;
  int n_d_ack = 0;
  int max_out = 0;
  int spur_req = 0;
  int spur_done = 0;
  bit rsp_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Memory model: answers each accepted request two cycles later, in order.
  always @(posedge clk) begin
    #1;
    m_rsp_val   = 1'b0;
    m_rsp_rdata = 32'h0;
    if (spur_req != spur_done) begin
      spur_done++;
      m_rsp_val   = 1'b1;
      m_rsp_rdata = 32'hBAD0BAD0;
    end else if (rst_n && rsp_en && mem_q.size() > 0 && cycle >= mem_q[0].t + 2) begin
      m_rsp_val   = 1'b1;
      m_rsp_rdata = mem_q[0].rdata;
      void'(mem_q.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_req_t  e;
    inflight_t a;
    if (rst_n && m_req_val && m_req_rdy) begin
      if (exp_req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got addr 0x%08h, expected no request", m_req_addr);
      end else begin
        e = exp_req_q.pop_front();
        chk("req_addr", m_req_addr, e.addr);
        chk("req_cop", {29'b0, m_req_cop}, {29'b0, e.cop});
        chk("req_wdata", m_req_wdata, e.wdata);
        chk("req_size", {29'b0, m_req_size}, {29'b0, e.size});
        mem_q.push_back('{e.src, e.rdata, cycle});
        exp_ack_q.push_back('{e.src, e.rdata, cycle});
        if (mem_q.size() > max_out) max_out = mem_q.size();
      end
    end
    if (i_req_ack || d_req_ack) begin
      if (i_req_ack && d_req_ack) begin
        checks++;
        errors++;
        $display("FAIL dual_ack: got both acks, expected one");
      end
      if (exp_ack_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got i=%0b d=%0b, expected none", i_req_ack, d_req_ack);
      end else begin
        a = exp_ack_q.pop_front();
        chk("ack_src", {31'b0, d_req_ack}, {31'b0, a.src});
        chk("ack_rdata", d_req_ack ? d_ack_rdata : i_ack_rdata, a.rdata);
      end
      if (i_req_ack) n_i_ack++;
      if (d_req_ack) n_d_ack++;
    end
  end

  task automatic do_fetch(input logic [31:0] addr);
    int n = 0;
    i_req_val  = 1'b1;
    i_req_addr = addr;
    do begin @(negedge clk); n++; end while (!i_req_ack && n < 100);
    if (!i_req_ack) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got no ack, expected ack for 0x%08h", addr);
    end
    @(posedge clk); #1;
    i_req_val = 1'b0;
  endtask

  task automatic do_data(input logic [31:0] addr, input logic [2:0] cop,
                         input logic [31:0] wdata, input logic [2:0] size);
    int n = 0;
    d_req_val   = 1'b1;
    d_req_addr  = addr;
    d_req_cop   = cop;
    d_req_wdata = wdata;
    d_req_size  = size;
    do begin @(negedge clk); n++; end while (!d_req_ack && n < 100);
    if (!d_req_ack) begin
      checks++;
      errors++;
      $display("FAIL data_timeout: got no ack, expected ack for 0x%08h", addr);
    end
    @(posedge clk); #1;
    d_req_val = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_req_q.size() + exp_ack_q.size() + mem_q.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_drain", exp_req_q.size() + exp_ack_q.size() + mem_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int ni, nd;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_req_val", m_req_val, 0);
    chk("rst_m_req_addr", m_req_addr, 0);
    chk("rst_m_req_cop", m_req_cop, 0);
    chk("rst_m_req_wdata", m_req_wdata, 0);
    chk("rst_m_req_size", m_req_size, 0);
    chk("rst_i_req_ack", i_req_ack, 0);
    chk("rst_d_req_ack", d_req_ack, 0);
    chk("rst_i_ack_rdata", i_ack_rdata, 0);
    chk("rst_d_ack_rdata", d_ack_rdata, 0);
    chk("rst_arb_err", arb_err, 0);
    rst_n     = 1'b1;
    m_req_rdy = 1'b1;
    @(posedge clk); #1;

    // Lone fetch
    exp_req_q.push_back('{SRC_I, 32'h100, 3'b000, 32'h0, 3'b100, 32'hDEADBEEF});
    fork
      do_fetch(32'h100);
      begin
        @(negedge clk); chk("t1_grant_cycle_val", m_req_val, 0);
        @(negedge clk); chk("t1_next_cycle_val", m_req_val, 1);
      end
    join
    wait_idle();
    chk("t1_i_acks", n_i_ack, 1);
    chk("t1_d_acks", n_d_ack, 0);

    // Simultaneous I and D: D wins the first tie
    exp_req_q.push_back('{SRC_D, 32'h2000, 3'b000, 32'h0, 3'b100, 32'h1});
    exp_req_q.push_back('{SRC_I, 32'h104, 3'b000, 32'h0, 3'b100, 32'h2});
    fork
      do_data(32'h2000, 3'b000, 32'h0, 3'b100);
      do_fetch(32'h104);
    join
    wait_idle();
    chk("t2_i_acks", n_i_ack, 2);
    chk("t2_d_acks", n_d_ack, 1);

    // Non-cacheable store
    exp_req_q.push_back('{SRC_D, 32'h2000_0010, 3'b011, 32'hCAFEF00D, 3'b100, 32'h0});
    do_data(32'h2000_0010, 3'b011, 32'hCAFEF00D, 3'b100);
    wait_idle();
    chk("t3_d_acks", n_d_ack, 2);

    // Backpressure: last grant was D, so I wins this tie
    m_req_rdy = 1'b0;
    exp_req_q.push_back('{SRC_I, 32'h3000, 3'b000, 32'h0, 3'b100, 32'h33});
    exp_req_q.push_back('{SRC_D, 32'h4000, 3'b000, 32'h55, 3'b010, 32'h44});
    fork
      do_fetch(32'h3000);
      do_data(32'h4000, 3'b000, 32'h55, 3'b010);
      begin
        @(negedge clk); chk("t4_grant_cycle_val", m_req_val, 0);
        repeat (5) begin
          @(negedge clk);
          chk("t4_stall_val", m_req_val, 1);
          chk("t4_stall_addr", m_req_addr, 32'h3000);
          chk("t4_stall_size", {29'b0, m_req_size}, 32'h4);
        end
        @(posedge clk); #1;
        m_req_rdy = 1'b1;
        @(negedge clk); chk("t4_accept_addr", m_req_addr, 32'h3000);
        @(negedge clk);
        chk("t4_nobubble_val", m_req_val, 1);
        chk("t4_nobubble_addr", m_req_addr, 32'h4000);
      end
    join
    wait_idle();
    chk("t4_i_acks", n_i_ack, 3);
    chk("t4_d_acks", n_d_ack, 3);

    // Spurious response after reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_err_before", arb_err, 0);
    ni = n_i_ack;
    nd = n_d_ack;
    spur_req++;
    repeat (3) @(negedge clk);
    chk("t5_err_set", arb_err, 1);
    chk("t5_no_i_ack", n_i_ack, ni);
    chk("t5_no_d_ack", n_d_ack, nd);
    repeat (5) @(negedge clk);
    chk("t5_err_sticky", arb_err, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t5_err_cleared", arb_err, 0);

    // Reset with two requests outstanding and a response on the wire
    @(posedge clk); #1;
    rst_n     = 1'b1;
    rsp_en    = 1'b0;
    m_req_rdy = 1'b1;
    exp_req_q.push_back('{SRC_D, 32'h600, 3'b000, 32'h0, 3'b001, 32'h22});
    exp_req_q.push_back('{SRC_I, 32'h500, 3'b000, 32'h0, 3'b100, 32'h11});
    i_req_val   = 1'b1;
    i_req_addr  = 32'h500;
    d_req_val   = 1'b1;
    d_req_addr  = 32'h600;
    d_req_cop   = 3'b000;
    d_req_wdata = 32'h0;
    d_req_size  = 3'b001;
    n = 0;
    while (exp_req_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("t6_both_accepted", exp_req_q.size(), 0);
    @(negedge clk);
    chk("t6_no_third_req", m_req_val, 0);
    chk("t6_addr_held", m_req_addr, 32'h500);
    rsp_en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(i_req_ack || d_req_ack) && n < 50);
    chk("t6_first_ack_d", d_req_ack, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_d_ack", d_req_ack, 0);
    chk("t6_rst_d_rdata", d_ack_rdata, 0);
    chk("t6_rst_i_ack", i_req_ack, 0);
    chk("t6_rst_m_req_val", m_req_val, 0);
    chk("t6_rst_m_req_addr", m_req_addr, 0);
    chk("t6_rst_m_req_size", {29'b0, m_req_size}, 0);
    chk("t6_rst_arb_err", arb_err, 0);
    i_req_val = 1'b0;
    d_req_val = 1'b0;
    mem_q.delete();
    exp_ack_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ni = n_i_ack;
    exp_req_q.push_back('{SRC_I, 32'h700, 3'b000, 32'h0, 3'b100, 32'h12345678});
    do_fetch(32'h700);
    wait_idle();
    chk("t6_fresh_fetch_ack", n_i_ack, ni + 1);
    chk("t6_err_clear", arb_err, 0);

    chk("max_outstanding_le2", {31'b0, max_out <= 2}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
